hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the 5-stage MIPS32 core.
- Tracks in-flight instructions from EX to WB in a shift-register scoreboard of DEPTH entries.
- Drives the ALU operand forward selects, the load-use stall (PC and IF/ID hold, ID/EX bubble) and the branch flush.
- Sits beside the pipeline registers. It is the next generation of the core's fixed, hazard-free pipeline: depth-generic, with stall and flush behaviour.

Parameters:
SIZE_ADDR_BR, 5, register-address width
DEPTH, 3, scoreboard entries (0=EX, 1=MEM, ..., DEPTH-1=WB); legal range 2..8
SEL_W, $clog2(DEPTH), forward-select width (derived localparam, not overridable)
STAT_W, 16, statistics counter width (used only with the optional feature)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
id_valid  in  1  ID stage holds a real instruction
id_rs  in  SIZE_ADDR_BR  ID source register 1
id_rt  in  SIZE_ADDR_BR  ID source register 2
id_uses_rt  in  1  ID instruction reads rt as an operand (R-type, store, beq)
id_rd  in  SIZE_ADDR_BR  ID resolved destination (after RegDest mux)
id_reg_write  in  1  ID RegWrite
id_mem_read  in  1  ID MemRead (load)
branch_taken  in  1  taken branch resolved in MEM (Branch & zero)
fwd_a_sel  out  SEL_W  ALU operand A source: 0=register file, k=stage k result
fwd_b_sel  out  SEL_W  ALU operand B source, same encoding
pc_write  out  1  PC enable
if_id_write  out  1  IF/ID enable
id_ex_bubble  out  1  zero ID/EX control fields this cycle
flush  out  1  invalidate IF/ID and ID/EX this cycle

Behaviour:
- Entry contents: valid, rs, rt, rd, reg_write, mem_read. On reset all entries are cleared (valid=0).
- Outputs while reset_n=0: fwd_a_sel=0, fwd_b_sel=0, pc_write=1, if_id_write=1, id_ex_bubble=0, flush=0.
- Shift: every clk edge, entry k <= entry k-1 for k>=1. Entry 0 <= ID fields when id_valid & !stall & !branch_taken; otherwise entry 0 becomes a bubble (valid=0, reg_write=0, mem_read=0).
- Load-use stall (combinational): stall = id_valid & e0.valid & e0.mem_read & e0.reg_write & e0.rd!=0 & (e0.rd==id_rs | (id_uses_rt & e0.rd==id_rt)).
  - While stall=1: pc_write=0, if_id_write=0, id_ex_bubble=1.
  - Stall lasts exactly 1 cycle per load-use pair; the load then reaches MEM and forwarding resolves the operand.
- Flush (combinational): flush = branch_taken. It forces id_ex_bubble=1 and pc_write=1 so the branch target loads.
  - Flush has priority over stall: if both are true, if_id_write=1 and stall has no effect.
  - Entry 0 gets a bubble on the next edge. Entries >=1 are not touched (they are older than the branch).
- Forwarding (combinational, from entry 0's rs/rt): fwd_a_sel = smallest k in 1..DEPTH-1 with ek.valid & ek.reg_write & ek.rd!=0 & ek.rd==e0.rs; 0 if none.
  - The youngest producer wins.
  - fwd_b_sel is computed the same way against e0.rt.
  - Entry 1 with mem_read=1 is never selected. The data is not ready, and stall prevents this case.
- Register $zero is never forwarded and never stalls.
- The WB-to-ID same-cycle read is served by the register-file write-through and is outside this block.
- Reset asserted mid-stall or mid-flush clears everything immediately. The first cycle after release has no hazard outputs.

Optional Feature:
- Macro HAZ_STATS_EN.
- Defined: adds outputs stall_cnt and flush_cnt (STAT_W each).
  - Each counts cycles with stall=1 (after flush priority) or flush=1.
  - Counters saturate at all-ones and are reset to 0 by reset_n.
- Undefined: no counters and no extra ports. All other behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - the sb_entry_t struct (valid, rs, rt, rd, reg_write, mem_read);
  - the FWD_REGFILE=0 constant;
  - the default SIZE_ADDR_BR.
- One sub-module, hazard_fwd_pick: a combinational priority encoder that takes the entries and one source register and returns the SEL_W select. It is instantiated twice.

Test Plan:
- Reset: hold reset_n=0 with random inputs -> all outputs at reset values. Release -> no stall or flush in the first cycle.
- EX-EX forward: add $3 then sub $5,$3,$4 back-to-back -> in the sub's EX cycle fwd_a_sel=1, fwd_b_sel=0, no stall.
- MEM-EX forward plus priority: add $3, add $3, and $6,$3,$3 -> fwd_a_sel=1 and fwd_b_sel=1 (younger add wins). Same sequence with a nop between -> sel=2.
- Load-use: lw $2,0($1) then add $4,$2,$2 -> exactly one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1, then fwd_a_sel=fwd_b_sel=2. Repeat with rd=$0 -> no stall.
- Branch flush with stall collision: branch_taken=1 in the same cycle as a load-use condition -> flush=1, pc_write=1, if_id_write=1, entry 0 bubbled; next cycle no stall.
- HAZ_STATS_EN: STAT_W=4 with 20 stall cycles -> stall_cnt saturates at 15. Asynchronous reset mid-run -> counters read 0.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: entry layout, forward-select
// encoding and the default register-address width.
package hazard_pkg;

   localparam int SIZE_ADDR_BR_DEF = 5;
   // Entries store addresses at this fixed width; narrower register files
   // are zero-extended so one struct serves every SIZE_ADDR_BR up to 8.
   localparam int ADDR_MAX_W       = 8;
   localparam int FWD_REGFILE      = 0;

   typedef logic [ADDR_MAX_W-1:0] reg_addr_t;

   typedef struct packed {
      logic      valid;
      reg_addr_t rs;
      reg_addr_t rt;
      reg_addr_t rd;
      logic      reg_write;
      logic      mem_read;
   } sb_entry_t;

   localparam sb_entry_t SB_EMPTY = '0;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request and hazard-control response bundle.
// Optional statistics ports appear when HAZ_STATS_EN is defined.
interface hazard_scoreboard_if #(
   parameter int SIZE_ADDR_BR = 5,
   parameter int DEPTH        = 3,
   parameter int STAT_W       = 16,
   localparam int SEL_W       = $clog2(DEPTH)
);
   logic                    id_valid;
   logic [SIZE_ADDR_BR-1:0] id_rs;
   logic [SIZE_ADDR_BR-1:0] id_rt;
   logic                    id_uses_rt;
   logic [SIZE_ADDR_BR-1:0] id_rd;
   logic                    id_reg_write;
   logic                    id_mem_read;
   logic                    branch_taken;
   logic [SEL_W-1:0]        fwd_a_sel;
   logic [SEL_W-1:0]        fwd_b_sel;
   logic                    pc_write;
   logic                    if_id_write;
   logic                    id_ex_bubble;
   logic                    flush;
`ifdef HAZ_STATS_EN
   logic [STAT_W-1:0]       stall_cnt;
   logic [STAT_W-1:0]       flush_cnt;
`endif

   modport master (
      output id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_reg_write,
             id_mem_read, branch_taken,
      input  fwd_a_sel, fwd_b_sel, pc_write, if_id_write, id_ex_bubble, flush
`ifdef HAZ_STATS_EN
      , input stall_cnt, flush_cnt
`endif
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_reg_write,
             id_mem_read, branch_taken,
      output fwd_a_sel, fwd_b_sel, pc_write, if_id_write, id_ex_bubble, flush
`ifdef HAZ_STATS_EN
      , output stall_cnt, flush_cnt
`endif
   );

endinterface

// File: rtl/hazard_scoreboard_fwd_pick.sv
// Priority encoder: picks the youngest in-flight producer of src.
// Entry 1 holding a load is skipped since its data is not yet available.
module hazard_fwd_pick
   import hazard_pkg::*;
#(
   parameter int DEPTH  = 3,
   localparam int SEL_W = $clog2(DEPTH)
) (
   input  sb_entry_t        entries [DEPTH],
   input  reg_addr_t        src,
   output logic [SEL_W-1:0] sel
);

   // Scan oldest to youngest so the youngest match overwrites the rest.
   always_comb begin
      sel = SEL_W'(FWD_REGFILE);
      for (int k = DEPTH - 1; k >= 1; k--) begin
         if (entries[k].valid && entries[k].reg_write &&
             (entries[k].rd != '0) && (entries[k].rd == src) &&
             !((k == 1) && entries[k].mem_read))
            sel = SEL_W'(k);
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller for the 5-stage pipeline.
// A DEPTH-entry shift register mirrors EX..WB; load-use stalls and
// branch flushes are combinational. Define HAZ_STATS_EN to add the
// saturating stall/flush cycle counters.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int SIZE_ADDR_BR = SIZE_ADDR_BR_DEF,
   parameter int DEPTH        = 3,
   parameter int STAT_W       = 16
) (
   input logic                clk,
   input logic                reset_n,
   hazard_scoreboard_if.slave bus
);

   sb_entry_t sb [DEPTH];
   sb_entry_t id_entry;
   logic      stall_raw;
   logic      stall;
   logic      flush_i;

   assign id_entry = '{valid:     1'b1,
                       rs:        reg_addr_t'(bus.id_rs),
                       rt:        reg_addr_t'(bus.id_rt),
                       rd:        reg_addr_t'(bus.id_rd),
                       reg_write: bus.id_reg_write,
                       mem_read:  bus.id_mem_read};

   // Load in EX feeding the instruction in ID; flush wins over stall.
   always_comb begin
      stall_raw = bus.id_valid && sb[0].valid && sb[0].mem_read &&
                  sb[0].reg_write && (sb[0].rd != '0) &&
                  ((sb[0].rd == id_entry.rs) ||
                   (bus.id_uses_rt && (sb[0].rd == id_entry.rt)));
      flush_i   = bus.branch_taken && reset_n;
      stall     = stall_raw && !flush_i;
   end

   assign bus.pc_write     = !stall;
   assign bus.if_id_write  = !stall;
   assign bus.id_ex_bubble = stall || flush_i;
   assign bus.flush        = flush_i;

   // Advance the scoreboard; a stalled or flushed ID slot enters as a bubble.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < DEPTH; k++) sb[k] <= SB_EMPTY;
      end else begin
         for (int k = DEPTH - 1; k >= 1; k--) sb[k] <= sb[k-1];
         sb[0] <= (bus.id_valid && !stall_raw && !bus.branch_taken) ?
                  id_entry : SB_EMPTY;
      end
   end

   hazard_fwd_pick #(.DEPTH(DEPTH)) u_pick_a (
      .entries (sb),
      .src     (sb[0].rs),
      .sel     (bus.fwd_a_sel)
   );

   hazard_fwd_pick #(.DEPTH(DEPTH)) u_pick_b (
      .entries (sb),
      .src     (sb[0].rt),
      .sel     (bus.fwd_b_sel)
   );

`ifdef HAZ_STATS_EN
   logic [STAT_W-1:0] stall_cnt_q;
   logic [STAT_W-1:0] flush_cnt_q;

   // Saturating cycle counters for effective stalls and flushes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
         if (flush_i && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed hazard scenarios followed by
// random instruction streams, all checked against an in-flight list model.
module tb_hazard_scoreboard;

   localparam int AW    = 5;
   localparam int DEPTH = 3;
`ifdef HAZ_STATS_EN
   localparam int STAT_W = 4;
`else
   localparam int STAT_W = 16;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   nvec = 0;
   int   nerr = 0;

   hazard_scoreboard_if #(.SIZE_ADDR_BR(AW), .DEPTH(DEPTH), .STAT_W(STAT_W)) bus ();

   hazard_scoreboard #(.SIZE_ADDR_BR(AW), .DEPTH(DEPTH), .STAT_W(STAT_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Model: list of in-flight instructions, index = cycles since leaving ID.
   typedef struct {
      bit v;
      int rs, rt, rd;
      bit rw, mr;
   } instr_t;

   instr_t inflight [DEPTH];
   bit     exp_stall_eff;
   bit     exp_enter;
   int     mstall_cnt = 0;
   int     mflush_cnt = 0;

   function automatic int producer_age(int src);
      // Youngest older instruction that will write src and whose result exists.
      for (int age = 1; age < DEPTH; age++) begin
         if (inflight[age].v && inflight[age].rw && inflight[age].rd != 0 &&
             inflight[age].rd == src && !(age == 1 && inflight[age].mr))
            return age;
      end
      return 0;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) inflight[i] = '{0, 0, 0, 0, 0, 0};
      mstall_cnt = 0;
      mflush_cnt = 0;
   endtask

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(bit v, int rs, int rt, bit ur, int rd, bit rw, bit mr, bit bt);
      bus.id_valid     = v;
      bus.id_rs        = AW'(rs);
      bus.id_rt        = AW'(rt);
      bus.id_uses_rt   = ur;
      bus.id_rd        = AW'(rd);
      bus.id_reg_write = rw;
      bus.id_mem_read  = mr;
      bus.branch_taken = bt;
   endtask

   task automatic nop();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic check_model();
      bit ld_use, stall_eff, fl;
      #1;
      if (!reset_n) begin
         ld_use = 0; fl = 0;
      end else begin
         ld_use = bus.id_valid && inflight[0].v && inflight[0].mr && inflight[0].rw &&
                  inflight[0].rd != 0 &&
                  (inflight[0].rd == int'(bus.id_rs) ||
                   (bus.id_uses_rt && inflight[0].rd == int'(bus.id_rt)));
         fl = bus.branch_taken;
      end
      stall_eff     = ld_use && !fl;
      exp_stall_eff = stall_eff;
      exp_enter     = bus.id_valid && !ld_use && !bus.branch_taken;
      check("fwd_a", 32'(bus.fwd_a_sel), reset_n ? producer_age(inflight[0].rs) : 0);
      check("fwd_b", 32'(bus.fwd_b_sel), reset_n ? producer_age(inflight[0].rt) : 0);
      check("pc_write", 32'(bus.pc_write), 32'(!stall_eff));
      check("if_id_write", 32'(bus.if_id_write), 32'(!stall_eff));
      check("id_ex_bubble", 32'(bus.id_ex_bubble), 32'(ld_use || fl));
      check("flush", 32'(bus.flush), 32'(fl));
`ifdef HAZ_STATS_EN
      check("stall_cnt", 32'(bus.stall_cnt), mstall_cnt);
      check("flush_cnt", 32'(bus.flush_cnt), mflush_cnt);
`endif
   endtask

   task automatic clock();
      instr_t nxt;
      bit fl;
      fl  = bus.branch_taken;
      nxt = exp_enter ? '{1, int'(bus.id_rs), int'(bus.id_rt), int'(bus.id_rd),
                          bus.id_reg_write, bus.id_mem_read}
                      : '{0, 0, 0, 0, 0, 0};
      @(posedge clk);
      if (!reset_n) begin
         model_clear();
      end else begin
         for (int i = DEPTH - 1; i >= 1; i--) inflight[i] = inflight[i-1];
         inflight[0] = nxt;
         if (exp_stall_eff && mstall_cnt < (1 << STAT_W) - 1) mstall_cnt++;
         if (fl && mflush_cnt < (1 << STAT_W) - 1) mflush_cnt++;
      end
      @(negedge clk);
   endtask

   task automatic step(bit v, int rs, int rt, bit ur, int rd, bit rw, bit mr, bit bt);
      drive(v, rs, rt, ur, rd, rw, mr, bt);
      check_model();
      clock();
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, "_fwd_a"}, 32'(bus.fwd_a_sel), 0);
      check({tag, "_fwd_b"}, 32'(bus.fwd_b_sel), 0);
      check({tag, "_pc"}, 32'(bus.pc_write), 1);
      check({tag, "_ifid"}, 32'(bus.if_id_write), 1);
      check({tag, "_bubble"}, 32'(bus.id_ex_bubble), 0);
      check({tag, "_flush"}, 32'(bus.flush), 0);
   endtask

   initial begin
      model_clear();
      nop();
      @(negedge clk);

      // Reset held with random inputs
      for (int i = 0; i < 4; i++) begin
         drive($urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 31),
               $urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 1),
               $urandom_range(0, 1), $urandom_range(0, 1));
         #1 check_reset_outputs("rst_hold");
         clock();
      end
      nop();
      reset_n = 1'b1;
      check_model();
      check_reset_outputs("rst_release");
      clock();

      // EX-EX forward: add $3 ; sub $5,$3,$4
      step(1, 1, 2, 1, 3, 1, 0, 0);
      step(1, 3, 4, 1, 5, 1, 0, 0);
      nop(); #1;
      check("exex_a", 32'(bus.fwd_a_sel), 1);
      check("exex_b", 32'(bus.fwd_b_sel), 0);
      check("exex_pc", 32'(bus.pc_write), 1);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);

      // Youngest producer wins
      step(1, 1, 2, 1, 3, 1, 0, 0);
      step(1, 4, 5, 1, 3, 1, 0, 0);
      step(1, 3, 3, 1, 6, 1, 0, 0);
      nop(); #1;
      check("prio_a", 32'(bus.fwd_a_sel), 1);
      check("prio_b", 32'(bus.fwd_b_sel), 1);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);

      // MEM-EX forward with a nop in between
      step(1, 1, 2, 1, 3, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 3, 3, 1, 6, 1, 0, 0);
      nop(); #1;
      check("mem_a", 32'(bus.fwd_a_sel), 2);
      check("mem_b", 32'(bus.fwd_b_sel), 2);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);

      // Load-use: lw $2,0($1) ; add $4,$2,$2
      step(1, 1, 2, 0, 2, 1, 1, 0);
      drive(1, 2, 2, 1, 4, 1, 0, 0);
      check_model();
      check("lu_pc", 32'(bus.pc_write), 0);
      check("lu_ifid", 32'(bus.if_id_write), 0);
      check("lu_bubble", 32'(bus.id_ex_bubble), 1);
      clock();
      drive(1, 2, 2, 1, 4, 1, 0, 0);
      check_model();
      check("lu_once_pc", 32'(bus.pc_write), 1);
      clock();
      nop(); #1;
      check("lu_fwd_a", 32'(bus.fwd_a_sel), 2);
      check("lu_fwd_b", 32'(bus.fwd_b_sel), 2);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);

      // Load into $zero never stalls
      step(1, 1, 0, 0, 0, 1, 1, 0);
      drive(1, 0, 0, 1, 4, 1, 0, 0);
      check_model();
      check("lu_zero_pc", 32'(bus.pc_write), 1);
      check("lu_zero_bubble", 32'(bus.id_ex_bubble), 0);
      clock();
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);

      // Branch flush colliding with a load-use
      step(1, 1, 0, 0, 7, 1, 1, 0);
      drive(1, 7, 0, 0, 4, 1, 0, 1);
      check_model();
      check("br_flush", 32'(bus.flush), 1);
      check("br_pc", 32'(bus.pc_write), 1);
      check("br_ifid", 32'(bus.if_id_write), 1);
      check("br_bubble", 32'(bus.id_ex_bubble), 1);
      clock();
      drive(1, 7, 0, 0, 4, 1, 0, 0);
      check_model();
      check("br_next_pc", 32'(bus.pc_write), 1);
      check("br_next_bubble", 32'(bus.id_ex_bubble), 0);
      clock();
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);

      // Asynchronous reset in the middle of a stall
      step(1, 1, 0, 0, 3, 1, 1, 0);
      drive(1, 3, 0, 0, 4, 1, 0, 1);
      check_model();
      drive(1, 3, 0, 0, 4, 1, 0, 0);
      #1 check("pre_rst_stall", 32'(bus.pc_write), 0);
      reset_n = 1'b0;
      #1 check_reset_outputs("rst_mid");
      clock();
      nop();
      reset_n = 1'b1;
      check_model();
      check_reset_outputs("rst_mid_release");
      clock();

`ifdef HAZ_STATS_EN
      // 20 load-use stalls and a few flushes: stall counter saturates
      for (int i = 0; i < 20; i++) begin
         step(1, 1, 0, 0, 2, 1, 1, 0);
         step(1, 2, 2, 1, 4, 1, 0, 0);
         step(0, 0, 0, 0, 0, 0, 0, i < 3);
      end
      nop(); #1;
      check("stall_sat", 32'(bus.stall_cnt), 15);
      check("flush_cnt3", 32'(bus.flush_cnt), 3);
      reset_n = 1'b0;
      #1 check("stall_cnt_rst", 32'(bus.stall_cnt), 0);
      check("flush_cnt_rst", 32'(bus.flush_cnt), 0);
      clock();
      reset_n = 1'b1;
      check_model();
      clock();
`endif

      // Random instruction stream over a small register set
      for (int i = 0; i < 400; i++) begin
         bit rw;
         rw = $urandom_range(0, 1);
         step($urandom_range(0, 3) != 0, $urandom_range(0, 5), $urandom_range(0, 5),
              $urandom_range(0, 1), $urandom_range(0, 5), rw,
              rw && ($urandom_range(0, 2) == 0), $urandom_range(0, 9) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   // Absolute time bound in case the stimulus stalls
   initial begin
      #200000;
      $display("FAIL timeout vectors=%0d expected completion", nvec);
      $fatal(1, "timeout");
   end

endmodule
